// File: rtl/gm_arbiter.sv
// Global-memory front end: round-robin arbitration of NUM_REQ single-word requesters onto one RAM port.
// Optional macro GM_ARB_STATS_EN adds saturating completed-read/write counters with a clear input.
module gm_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ADDR_W  = 17,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned RAM_LAT = 2
) (
    input  logic                      clock_50,
    input  logic                      reset_n,
    input  logic [NUM_REQ-1:0]        lm_gm_re,
    input  logic [NUM_REQ-1:0]        lm_gm_we,
    input  logic [NUM_REQ*ADDR_W-1:0] lm_gm_addr,
    input  logic [NUM_REQ*DATA_W-1:0] lm_gm_data,
    output logic [DATA_W-1:0]         gm_lm_data,
    output logic [NUM_REQ-1:0]        gm_lm_ack,
    output logic [ADDR_W-1:0]         gm_ram_addr,
    output logic [DATA_W-1:0]         gm_ram_data,
    output logic                      gm_ram_we,
    input  logic [DATA_W-1:0]         gm_ram_q,
    output logic                      gm_busy
`ifdef GM_ARB_STATS_EN
    ,
    input  logic                      stat_clr,
    output logic [15:0]               stat_reads,
    output logic [15:0]               stat_writes
`endif
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);
    localparam int unsigned CNT_W = $clog2(RAM_LAT + 1);

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait,
        StAck
    } state_e;

    state_e              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [IDX_W-1:0]    last_q, last_d;
    logic                op_wr_q, op_wr_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;

    logic [NUM_REQ-1:0]  pend;
    logic                grant_vld;
    logic [IDX_W-1:0]    grant_idx;
    logic [IDX_W-1:0]    scan_idx;

    // A requester asserting both re and we is served as a write.
    assign pend = lm_gm_re | lm_gm_we;

    // Round-robin scan starting just after the last granted index.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        scan_idx  = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            scan_idx = IDX_W'((32'(last_q) + k) % NUM_REQ);
            if (!grant_vld && pend[scan_idx]) begin
                grant_vld = 1'b1;
                grant_idx = scan_idx;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        last_d  = last_q;
        op_wr_d = op_wr_q;
        addr_d  = addr_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        unique case (state_q)
            StIdle: begin
                if (grant_vld) begin
                    idx_d   = grant_idx;
                    op_wr_d = lm_gm_we[grant_idx];
                    addr_d  = lm_gm_addr[grant_idx*ADDR_W +: ADDR_W];
                    data_d  = lm_gm_data[grant_idx*DATA_W +: DATA_W];
                    state_d = StIssue;
                end
            end
            StIssue: begin
                if (op_wr_q) begin
                    state_d = StAck;
                end else begin
                    cnt_d   = CNT_W'(RAM_LAT);
                    state_d = StWait;
                end
            end
            StWait: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    rdata_d = gm_ram_q;
                    state_d = StAck;
                end
            end
            StAck: begin
                last_d  = idx_q;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock_50 or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            idx_q   <= '0;
            last_q  <= IDX_W'(NUM_REQ - 1);
            op_wr_q <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            cnt_q   <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
            op_wr_q <= op_wr_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
        end
    end

    // Outputs decode straight from registered state so reset clears them without a clock edge.
    always_comb begin
        gm_lm_ack = '0;
        if (state_q == StAck) begin
            gm_lm_ack[idx_q] = 1'b1;
        end
    end

    assign gm_ram_we   = (state_q == StIssue) && op_wr_q;
    assign gm_busy     = (state_q != StIdle);
    assign gm_ram_addr = addr_q;
    assign gm_ram_data = data_q;
    assign gm_lm_data  = rdata_q;

`ifdef GM_ARB_STATS_EN
    logic [15:0] stat_reads_q;
    logic [15:0] stat_writes_q;

    always_ff @(posedge clock_50 or negedge reset_n) begin
        if (!reset_n) begin
            stat_reads_q  <= '0;
            stat_writes_q <= '0;
        end else if (stat_clr) begin
            stat_reads_q  <= '0;
            stat_writes_q <= '0;
        end else if (state_q == StAck) begin
            if (op_wr_q) begin
                if (stat_writes_q != 16'hFFFF) stat_writes_q <= stat_writes_q + 16'd1;
            end else begin
                if (stat_reads_q != 16'hFFFF) stat_reads_q <= stat_reads_q + 16'd1;
            end
        end
    end

    assign stat_reads  = stat_reads_q;
    assign stat_writes = stat_writes_q;
`endif

    ack_onehot_a: assert property (@(posedge clock_50) disable iff (!reset_n) $onehot0(gm_lm_ack));
    we_busy_a:    assert property (@(posedge clock_50) disable iff (!reset_n) gm_ram_we |-> gm_busy);

endmodule

// File: tb/tb_gm_arbiter.sv
// Testbench for gm_arbiter: directed vector table, reset/fairness sequences, and random traffic
// checked against a transaction-level round-robin model with its own copy of RAM contents.
module tb_gm_arbiter;

    localparam int NUM_REQ = 4;
    localparam int ADDR_W  = 17;
    localparam int DATA_W  = 32;
    localparam int RAM_LAT = 2;

    logic                      clock_50;
    logic                      reset_n;
    logic [NUM_REQ-1:0]        lm_gm_re;
    logic [NUM_REQ-1:0]        lm_gm_we;
    logic [NUM_REQ*ADDR_W-1:0] lm_gm_addr;
    logic [NUM_REQ*DATA_W-1:0] lm_gm_data;
    logic [DATA_W-1:0]         gm_lm_data;
    logic [NUM_REQ-1:0]        gm_lm_ack;
    logic [ADDR_W-1:0]         gm_ram_addr;
    logic [DATA_W-1:0]         gm_ram_data;
    logic                      gm_ram_we;
    logic [DATA_W-1:0]         gm_ram_q;
    logic                      gm_busy;
`ifdef GM_ARB_STATS_EN
    logic                      stat_clr;
    logic [15:0]               stat_reads;
    logic [15:0]               stat_writes;
`endif

    gm_arbiter #(
        .NUM_REQ(NUM_REQ),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .RAM_LAT(RAM_LAT)
    ) dut (
        .clock_50   (clock_50),
        .reset_n    (reset_n),
        .lm_gm_re   (lm_gm_re),
        .lm_gm_we   (lm_gm_we),
        .lm_gm_addr (lm_gm_addr),
        .lm_gm_data (lm_gm_data),
        .gm_lm_data (gm_lm_data),
        .gm_lm_ack  (gm_lm_ack),
        .gm_ram_addr(gm_ram_addr),
        .gm_ram_data(gm_ram_data),
        .gm_ram_we  (gm_ram_we),
        .gm_ram_q   (gm_ram_q),
        .gm_busy    (gm_busy)
`ifdef GM_ARB_STATS_EN
        ,
        .stat_clr   (stat_clr),
        .stat_reads (stat_reads),
        .stat_writes(stat_writes)
`endif
    );

    initial clock_50 = 1'b0;
    always #5 clock_50 = ~clock_50;

    function automatic logic [31:0] init_word(input int i);
        if (i == 255) return 32'hCAFEF00D;
        return (32'(i) * 32'h01000193) ^ 32'h5A5A0000;
    endfunction

    // RAM environment: 256 words indexed by addr[7:0], RAM_LAT-deep read pipeline.
    logic              ram_init;
    logic [31:0]       mem  [0:255];
    logic [31:0]       pipe [0:RAM_LAT-1];

    always @(posedge clock_50) begin
        pipe[0] <= mem[gm_ram_addr[7:0]];
        for (int i = 1; i < RAM_LAT; i++) pipe[i] <= pipe[i-1];
        if (ram_init) begin
            for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
        end else if (gm_ram_we) begin
            mem[gm_ram_addr[7:0]] <= gm_ram_data;
        end
    end
    assign gm_ram_q = pipe[RAM_LAT-1];

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [NUM_REQ-1:0] oh(input int i);
        logic [NUM_REQ-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, 64'(gm_busy), 64'd0);
        check({tag, "_ack"}, 64'(gm_lm_ack), 64'd0);
        check({tag, "_ram_we"}, 64'(gm_ram_we), 64'd0);
        check({tag, "_ram_addr"}, 64'(gm_ram_addr), 64'd0);
        check({tag, "_ram_data"}, 64'(gm_ram_data), 64'd0);
        check({tag, "_lm_data"}, 64'(gm_lm_data), 64'd0);
    endtask

    task automatic set_req(input int i, input logic re, input logic we,
                           input logic [16:0] addr, input logic [31:0] data);
        lm_gm_re[i] = re;
        lm_gm_we[i] = we;
        lm_gm_addr[i*ADDR_W +: ADDR_W] = addr;
        lm_gm_data[i*DATA_W +: DATA_W] = data;
    endtask

    typedef struct {
        int          idx;
        logic        re;
        logic        we;
        logic [16:0] addr;
        logic [31:0] data;
        int          lat;
        logic        chk_rd;
        logic [31:0] rdata;
    } vec_t;

    // Single transaction from idle; called #1 after a rising edge.
    task automatic run_vec(input vec_t v, input string tag);
        int                 k;
        logic [NUM_REQ-1:0] ack_seen;
        logic               we_i;
        logic [16:0]        addr_i;
        logic [31:0]        data_i;
        set_req(v.idx, v.re, v.we, v.addr, v.data);
        k        = 0;
        ack_seen = '0;
        we_i     = 1'b0;
        addr_i   = '0;
        data_i   = '0;
        while (ack_seen == '0 && k < 20) begin
            @(posedge clock_50);
            #1;
            k++;
            if (k == 1) begin
                we_i   = gm_ram_we;
                addr_i = gm_ram_addr;
                data_i = gm_ram_data;
            end
            ack_seen = gm_lm_ack;
        end
        lm_gm_re = '0;
        lm_gm_we = '0;
        check({tag, "_ack"}, 64'(ack_seen), 64'(oh(v.idx)));
        check({tag, "_lat"}, 64'(k), 64'(v.lat));
        check({tag, "_issue_we"}, 64'(we_i), 64'(v.we));
        check({tag, "_issue_addr"}, 64'(addr_i), 64'(v.addr));
        if (v.we) check({tag, "_issue_data"}, 64'(data_i), 64'(v.data));
        if (v.chk_rd) check({tag, "_lm_data"}, 64'(gm_lm_data), 64'(v.rdata));
        @(posedge clock_50);
        #1;
    endtask

    vec_t dir_vecs[6];
`ifdef GM_ARB_STATS_EN
    vec_t st_vecs[6];
`endif
    logic [31:0] ref_mem [0:255];

    // Random-traffic requester state and transaction-level model.
    logic        act   [NUM_REQ];
    logic        rq_re [NUM_REQ];
    logic        rq_we [NUM_REQ];
    logic [16:0] rq_ad [NUM_REQ];
    logic [31:0] rq_dt [NUM_REQ];

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int                 n_got;
        int                 exp_order[3];
        int                 pend_raise;
        int                 got;
        logic [NUM_REQ-1:0] a;
        int                 st_cyc, ack_cyc, free_at, cur, last;
        logic               cur_wr;
        logic [16:0]        cur_addr;
        logic [31:0]        cur_data;
        int                 op;

        dir_vecs[0] = '{1, 1'b0, 1'b1, 17'h00010, 32'hDEADBEEF, 2, 1'b1, 32'h0};
        dir_vecs[1] = '{3, 1'b1, 1'b0, 17'h1FFFF, 32'h0, 4, 1'b1, 32'hCAFEF00D};
        dir_vecs[2] = '{0, 1'b0, 1'b1, 17'h00020, 32'h12345678, 2, 1'b1, 32'hCAFEF00D};
        dir_vecs[3] = '{2, 1'b1, 1'b0, 17'h00010, 32'h0, 4, 1'b1, 32'hDEADBEEF};
        dir_vecs[4] = '{1, 1'b1, 1'b1, 17'h00030, 32'hA5A5A5A5, 2, 1'b1, 32'hDEADBEEF};
        dir_vecs[5] = '{0, 1'b1, 1'b0, 17'h00030, 32'h0, 4, 1'b1, 32'hA5A5A5A5};
`ifdef GM_ARB_STATS_EN
        st_vecs[0] = '{0, 1'b0, 1'b1, 17'h00050, 32'h1, 2, 1'b0, 32'h0};
        st_vecs[1] = '{1, 1'b1, 1'b0, 17'h00050, 32'h0, 4, 1'b1, 32'h1};
        st_vecs[2] = '{2, 1'b0, 1'b1, 17'h00051, 32'h2, 2, 1'b0, 32'h0};
        st_vecs[3] = '{3, 1'b1, 1'b0, 17'h00051, 32'h0, 4, 1'b1, 32'h2};
        st_vecs[4] = '{0, 1'b1, 1'b0, 17'h00050, 32'h0, 4, 1'b1, 32'h1};
        st_vecs[5] = '{1, 1'b1, 1'b0, 17'h00051, 32'h0, 4, 1'b1, 32'h2};
        stat_clr = 1'b0;
`endif

        reset_n    = 1'b0;
        ram_init   = 1'b1;
        lm_gm_re   = '0;
        lm_gm_we   = '0;
        lm_gm_addr = '0;
        lm_gm_data = '0;
        repeat (2) @(posedge clock_50);
        #1;
        check_all_zero("por");
        reset_n  = 1'b1;
        ram_init = 1'b0;

        for (int i = 0; i < 6; i++) run_vec(dir_vecs[i], $sformatf("vec%0d", i));

        // Reset during WAIT of a read, then restart with several requesters pending.
        set_req(3, 1'b1, 1'b0, 17'h1FFFF, 32'h0);
        @(posedge clock_50); #1;
        @(posedge clock_50); #1;
        check("mid_busy_before_rst", 64'(gm_busy), 64'd1);
        #2 reset_n = 1'b0;
        #1 check_all_zero("mid_rst");
        set_req(0, 1'b0, 1'b1, 17'h00040, 32'h11112222);
        set_req(1, 1'b1, 1'b0, 17'h00040, 32'h0);
        repeat (2) begin
            @(posedge clock_50); #1;
            check("rst_hold_ack", 64'(gm_lm_ack), 64'd0);
            check("rst_hold_busy", 64'(gm_busy), 64'd0);
        end
        #2 reset_n = 1'b1;
        exp_order = '{0, 1, 3};
        n_got = 0;
        for (int t = 0; t < 30 && n_got < 3; t++) begin
            @(posedge clock_50); #1;
            if (gm_lm_ack != '0) begin
                check($sformatf("restart_ack%0d", n_got), 64'(gm_lm_ack),
                      64'(oh(exp_order[n_got])));
                if (exp_order[n_got] == 1)
                    check("restart_rd1", 64'(gm_lm_data), 64'h11112222);
                if (exp_order[n_got] == 3)
                    check("restart_rd3", 64'(gm_lm_data), 64'hCAFEF00D);
                lm_gm_re[exp_order[n_got]] = 1'b0;
                lm_gm_we[exp_order[n_got]] = 1'b0;
                n_got++;
            end
        end
        check("restart_count", 64'(n_got), 64'd3);
        @(posedge clock_50); #1;

        // Fairness: everyone re-requests in the cycle after its ack.
        for (int i = 0; i < NUM_REQ; i++) set_req(i, 1'b0, 1'b1, 17'(32'h60 + i), 32'(i));
        pend_raise = -1;
        for (int g = 0; g < 8; g++) begin
            got = 0;
            a   = '0;
            for (int t = 0; t < 10 && got == 0; t++) begin
                @(posedge clock_50); #1;
                if (pend_raise >= 0) begin
                    lm_gm_we[pend_raise] = 1'b1;
                    pend_raise = -1;
                end
                if (gm_lm_ack != '0) begin
                    got = 1;
                    a   = gm_lm_ack;
                    for (int i = 0; i < NUM_REQ; i++) begin
                        if (a[i]) begin
                            lm_gm_we[i] = 1'b0;
                            pend_raise  = i;
                        end
                    end
                end
            end
            check($sformatf("fair_grant%0d", g), 64'(a), 64'(oh(g % NUM_REQ)));
        end
        lm_gm_we = '0;
        ram_init = 1'b1;
        @(posedge clock_50); #1;
        ram_init = 1'b0;
        for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);

        // Random traffic against the transaction-level model.
        for (int i = 0; i < NUM_REQ; i++) begin
            act[i]   = 1'b0;
            rq_re[i] = 1'b0;
            rq_we[i] = 1'b0;
            rq_ad[i] = '0;
            rq_dt[i] = '0;
        end
        st_cyc   = -100;
        ack_cyc  = -100;
        free_at  = 0;
        last     = NUM_REQ - 1;
        cur      = 0;
        cur_wr   = 1'b0;
        cur_addr = '0;
        cur_data = '0;
        for (int c = 1; c <= 2000; c++) begin
            @(posedge clock_50); #1;
            check("rnd_busy", 64'(gm_busy), 64'(c > st_cyc && c <= ack_cyc));
            check("rnd_ack", 64'(gm_lm_ack), (c == ack_cyc) ? 64'(oh(cur)) : 64'd0);
            check("rnd_ram_we", 64'(gm_ram_we), 64'((c == st_cyc + 1) && cur_wr));
            if (c == st_cyc + 1) begin
                check("rnd_ram_addr", 64'(gm_ram_addr), 64'(cur_addr));
                if (cur_wr) begin
                    check("rnd_ram_data", 64'(gm_ram_data), 64'(cur_data));
                    ref_mem[cur_addr[7:0]] = cur_data;
                end
            end
            if (c == ack_cyc) begin
                if (!cur_wr) check("rnd_rdata", 64'(gm_lm_data), 64'(ref_mem[cur_addr[7:0]]));
                act[cur] = 1'b0;
            end
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!act[i] && !(c == ack_cyc && i == cur) && $urandom_range(3) == 0) begin
                    op       = int'($urandom_range(2));
                    act[i]   = 1'b1;
                    rq_re[i] = (op != 1);
                    rq_we[i] = (op != 0);
                    rq_ad[i] = 17'($urandom);
                    rq_dt[i] = $urandom;
                end
            end
            for (int i = 0; i < NUM_REQ; i++)
                set_req(i, act[i] & rq_re[i], act[i] & rq_we[i], rq_ad[i], rq_dt[i]);
            if (c >= free_at) begin
                got = 0;
                for (int k = 1; k <= NUM_REQ; k++) begin
                    if (got == 0 && act[(last + k) % NUM_REQ]) begin
                        got      = 1;
                        cur      = (last + k) % NUM_REQ;
                        cur_wr   = rq_we[cur];
                        cur_addr = rq_ad[cur];
                        cur_data = rq_dt[cur];
                        st_cyc   = c;
                        ack_cyc  = c + (cur_wr ? 2 : 2 + RAM_LAT);
                        free_at  = ack_cyc + 1;
                    end
                end
                if (got != 0) last = cur;
            end
        end
        lm_gm_re = '0;
        lm_gm_we = '0;
        repeat (8) @(posedge clock_50);
        #1;

`ifdef GM_ARB_STATS_EN
        stat_clr = 1'b1;
        @(posedge clock_50); #1;
        stat_clr = 1'b0;
        check("stat_clr_reads", 64'(stat_reads), 64'd0);
        check("stat_clr_writes", 64'(stat_writes), 64'd0);
        for (int i = 0; i < 5; i++) run_vec(st_vecs[i], $sformatf("stvec%0d", i));
        check("stat_reads3", 64'(stat_reads), 64'd3);
        check("stat_writes2", 64'(stat_writes), 64'd2);
        stat_clr = 1'b1;
        @(posedge clock_50); #1;
        stat_clr = 1'b0;
        check("stat_clr2_reads", 64'(stat_reads), 64'd0);
        check("stat_clr2_writes", 64'(stat_writes), 64'd0);
        force dut.stat_reads_q = 16'hFFFF;
        @(posedge clock_50); #1;
        release dut.stat_reads_q;
        run_vec(st_vecs[5], "stvec5");
        check("stat_sat", 64'(stat_reads), 64'hFFFF);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
